// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
// ----------------------------------------------------------------------------
// Multi-cycle load/store unit between the MEM pipeline stage and a data
// memory bus with wait states. One access is accepted per request handshake.
// The unit checks alignment, drives byte-lane selects and lane-positioned
// store data, waits for the memory ack, and returns formatted load data or
// an exception flag through a response handshake. A bus timeout, a flush
// (cancel) input and response back-pressure are supported.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   opcode, addr, wdata access type, byte address, right-justified store data
//   flush               cancel the in-flight or pending access
//   resp_valid/ready    response handshake
//   resp_rdata          formatted load data (0 for stores and exceptions)
//   adel, ades, buserr  load/store address error, ack timeout
//   badvaddr            faulting address when any flag is set, else 0
//   mem_en/we/sel/addr/wdata   bus request towards data memory
//   mem_rdata, mem_ack  read word and completion from data memory
//
// Opcodes use the MIPS primary opcode encoding:
//   LB=0x20 LH=0x21 LW=0x23 LBU=0x24 LHU=0x25 SB=0x28 SH=0x29 SW=0x2B
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT_W  = 8,
    parameter bit SEXT_SB_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              adel,
    output logic              ades,
    output logic              buserr,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [1:0]            size_reg;
    logic                  signed_reg;
    logic                  load_reg;
    logic                  cancel_reg;
    logic [TIMEOUT_W-1:0]  cnt_reg;

    // ------------------------------------------------------------------
    // Opcode decode (from the live request inputs)
    // ------------------------------------------------------------------
    logic       dec_load;
    logic       dec_store;
    logic       dec_signed;
    logic       dec_known;
    logic [1:0] dec_size;
    logic       dec_misaligned;

    always_comb begin
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_signed = 1'b0;
        dec_known  = 1'b1;
        dec_size   = SZ_B;
        case (opcode)
            OP_LB:  begin dec_load  = 1'b1; dec_size = SZ_B; dec_signed = 1'b1; end
            OP_LBU: begin dec_load  = 1'b1; dec_size = SZ_B; end
            OP_LH:  begin dec_load  = 1'b1; dec_size = SZ_H; dec_signed = 1'b1; end
            OP_LHU: begin dec_load  = 1'b1; dec_size = SZ_H; end
            OP_LW:  begin dec_load  = 1'b1; dec_size = SZ_W; end
            OP_SB:  begin dec_store = 1'b1; dec_size = SZ_B; end
            OP_SH:  begin dec_store = 1'b1; dec_size = SZ_H; end
            OP_SW:  begin dec_store = 1'b1; dec_size = SZ_W; end
            default: dec_known = 1'b0;
        endcase
        // Byte accesses can never be misaligned; unknown opcodes decode as bytes.
        dec_misaligned = ((dec_size == SZ_H) && addr[0]) ||
                         ((dec_size == SZ_W) && (addr[1:0] != 2'b00));
    end

    // ------------------------------------------------------------------
    // Per-lane store data / select, and read lane extraction
    // ------------------------------------------------------------------
    logic [3:0]  st_sel;
    logic [31:0] st_wdata;
    logic [7:0]  rd_lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       own;
            logic [7:0] own_byte;
            logic [7:0] fill_byte;

            always_comb begin
                own       = 1'b1;
                own_byte  = wdata[8*gi +: 8];
                fill_byte = wdata[8*gi +: 8];
                case (dec_size)
                    SZ_B: begin
                        own       = (addr[1:0] == LANE);
                        own_byte  = wdata[7:0];
                        fill_byte = SEXT_SB_EN ? {8{wdata[7]}} : wdata[7:0];
                    end
                    SZ_H: begin
                        own       = (addr[1] == LANE[1]);
                        own_byte  = LANE[0] ? wdata[15:8] : wdata[7:0];
                        fill_byte = SEXT_SB_EN ? {8{wdata[15]}} : own_byte;
                    end
                    default: begin
                        own       = 1'b1;
                        own_byte  = wdata[8*gi +: 8];
                        fill_byte = wdata[8*gi +: 8];
                    end
                endcase
            end

            assign st_sel[gi]          = own;
            assign st_wdata[8*gi +: 8] = own ? own_byte : fill_byte;
            assign rd_lane[gi]         = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load formatting from the registered access type and address
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = rd_lane[addr_reg[1:0]];
        ld_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_reg)
            SZ_B:    ld_data = {{24{signed_reg & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{signed_reg & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    logic cancel_now;
    assign cancel_now = cancel_reg | flush;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            size_reg   <= SZ_B;
            signed_reg <= 1'b0;
            load_reg   <= 1'b0;
            cancel_reg <= 1'b0;
            cnt_reg    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            adel       <= 1'b0;
            ades       <= 1'b0;
            buserr     <= 1'b0;
            badvaddr   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A flush in the same cycle suppresses acceptance.
                    if (req_valid && req_ready && !flush) begin
                        addr_reg   <= addr;
                        size_reg   <= dec_size;
                        signed_reg <= dec_signed;
                        load_reg   <= dec_load;
                        req_ready  <= 1'b0;
                        if (dec_known && !dec_misaligned) begin
                            state_reg  <= ST_REQ;
                            cancel_reg <= 1'b0;
                            // Counter counts REQ cycles including the current one.
                            cnt_reg    <= TIMEOUT_W'(1);
                            mem_en     <= 1'b1;
                            mem_we     <= dec_store;
                            mem_sel    <= dec_store ? st_sel : 4'b0000;
                            mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wdata  <= dec_store ? st_wdata : 32'h0;
                        end else begin
                            state_reg  <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            adel       <= dec_load & dec_misaligned;
                            ades       <= dec_store & dec_misaligned;
                            buserr     <= 1'b0;
                            badvaddr   <= dec_misaligned ? addr : '0;
                        end
                    end
                end

                ST_REQ: begin
                    cancel_reg <= cancel_now;
                    // Ack is checked first so a simultaneous ack beats the timeout.
                    if (mem_ack || (cnt_reg == {TIMEOUT_W{1'b1}})) begin
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_sel    <= '0;
                        cnt_reg    <= '0;
                        if (cancel_now) begin
                            state_reg  <= ST_IDLE;
                            cancel_reg <= 1'b0;
                            req_ready  <= 1'b1;
                        end else begin
                            state_reg  <= ST_RESP;
                            resp_valid <= 1'b1;
                            adel       <= 1'b0;
                            ades       <= 1'b0;
                            if (mem_ack) begin
                                resp_rdata <= load_reg ? ld_data : 32'h0;
                                buserr     <= 1'b0;
                                badvaddr   <= '0;
                            end else begin
                                resp_rdata <= '0;
                                buserr     <= 1'b1;
                                badvaddr   <= addr_reg;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RESP: begin
                    // Flush discards the held response just like a consume.
                    if (resp_ready || flush) begin
                        state_reg  <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        adel       <= 1'b0;
                        ades       <= 1'b0;
                        buserr     <= 1'b0;
                        badvaddr   <= '0;
                    end
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_sel    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
// Randomized and directed bench for mem_access_unit. Expected bus fields and
// responses come from arithmetic reference functions describing the access
// rules (sizes, lane masks, shifts and sign extension).
// ============================================================================
module tb_mem_access_unit;

    localparam int ADDR_W     = 32;
    localparam int TIMEOUT_W  = 8;
    localparam bit SEXT_SB_EN = 1'b0;
    localparam int TIMEOUT_CYC = (1 << TIMEOUT_W) - 1;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              flush;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              adel;
    logic              ades;
    logic              buserr;
    logic [ADDR_W-1:0] badvaddr;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W     (ADDR_W),
        .TIMEOUT_W  (TIMEOUT_W),
        .SEXT_SB_EN (SEXT_SB_EN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .addr       (addr),
        .wdata      (wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .adel       (adel),
        .ades       (ades),
        .buserr     (buserr),
        .badvaddr   (badvaddr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
        int sz;
        sz = op_size(op);
        if (sz == 0) return 1'b0;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [5:0] op, input logic [31:0] a);
        int sz;
        if (!op_store(op)) return 4'b0000;
        sz = op_size(op);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] d);
        int     sz;
        int     sh;
        longint lo;
        longint lane_mask;
        longint base;
        sz = op_size(op);
        if (!op_store(op)) return 32'h0;
        if (sz == 4) return d;
        sh        = 8 * (a % 4);
        lane_mask = (64'd1 << (8 * sz)) - 1;
        lo        = longint'(d) & lane_mask;
        if (SEXT_SB_EN)
            base = (lo >= (64'd1 << (8 * sz - 1))) ? 64'hFFFF_FFFF : 64'd0;
        else
            base = (sz == 1) ? lo * 64'h0101_0101 : lo * 64'h0001_0001;
        return 32'((base & ~(lane_mask << sh)) | (lo << sh));
    endfunction

    function automatic logic [31:0] m_rdata(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] r);
        int     sz;
        longint v;
        if (!op_load(op)) return 32'h0;
        sz = op_size(op);
        v  = (longint'(r) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (((op == OP_LB) || (op == OP_LH)) && (v >= (64'd1 << (8 * sz - 1))))
            v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    // ---------------- transaction driver ----------------
    task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits, input int hold);
        bit          exc;
        logic [31:0] e_rdata;
        logic [31:0] e_bad;
        logic [2:0]  e_flags;
        logic [31:0] rnd;
        exc     = (op_size(op) == 0) || m_misaligned(op, a);
        e_rdata = (exc) ? 32'h0 : m_rdata(op, a, rd);
        e_flags = {op_load(op) && m_misaligned(op, a), op_store(op) && m_misaligned(op, a), 1'b0};
        e_bad   = m_misaligned(op, a) ? a : 32'h0;

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        // Scramble request inputs: the unit must work from registered copies.
        req_valid = 1'b0;
        rnd       = $urandom;
        opcode    = rnd[5:0];
        addr      = $urandom;
        wdata     = $urandom;
        check("req_ready_busy", req_ready, 0);
        if (!exc) begin
            for (int i = 0; i <= waits; i++) begin
                check("mem_en", mem_en, 1);
                check("mem_we", mem_we, op_store(op));
                check("mem_sel", mem_sel, m_sel(op, a));
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                if (op_store(op)) check("mem_wdata", mem_wdata, m_wdata(op, a, wd));
                check("resp_valid_req", resp_valid, 0);
                if (i == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        check("mem_en_resp", mem_en, 0);
        check("resp_valid", resp_valid, 1);
        check("resp_rdata", resp_rdata, e_rdata);
        check("flags", {adel, ades, buserr}, e_flags);
        check("badvaddr", badvaddr, e_bad);
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, e_rdata);
            check("hold_flags", {adel, ades, buserr}, e_flags);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_done", resp_valid, 0);
        check("req_ready_back", req_ready, 1);
        $display("TXN op=%h addr=%h wdata=%h waits=%0d hold=%0d exp_rdata=%h exp_flags=%b",
                 op, a, wd, waits, hold, e_rdata, e_flags);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] r;
        int          n;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'h00, 6'h3F};

        rst = 1'b1; req_valid = 1'b0; opcode = '0; addr = '0; wdata = '0;
        flush = 1'b0; resp_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_outs", {resp_valid, adel, ades, buserr, mem_en, mem_we, mem_sel}, 0);
        check("rst_data", {resp_rdata, badvaddr, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(OP_LB, 32'h103, 32'h0, 32'h80FF_1234, 3, 0);
        run_txn(OP_SH, 32'h202, 32'h0000_BEEF, 32'h0, 1, 0);
        run_txn(OP_LW, 32'h006, 32'h0, 32'h0, 0, 1);
        run_txn(OP_LHU, 32'h012, 32'h0, 32'h8765_4321, 0, 4);
        run_txn(OP_SB, 32'h301, 32'h0000_00A5, 32'h0, 2, 0);
        run_txn(OP_SH, 32'h401, 32'h1234, 32'h0, 0, 0);
        run_txn(6'h3E, 32'h500, 32'h0, 32'h0, 0, 2);
        // Ack arrives in the last REQ cycle: ack must beat the timeout.
        run_txn(OP_LH, 32'h602, 32'h0, 32'hC001_7FFF, TIMEOUT_CYC - 1, 0);

        // Timeout: SW with no ack
        req_valid = 1'b1; opcode = OP_SW; addr = 32'h0000_0700; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (mem_en && n < 400) begin
            n++;
            check("to_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        check("to_req_cycles", n, TIMEOUT_CYC);
        check("to_resp_valid", resp_valid, 1);
        check("to_buserr", {adel, ades, buserr}, 3'b001);
        check("to_badvaddr", badvaddr, 32'h700);
        check("to_rdata", resp_rdata, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("to_done", resp_valid, 0);
        $display("TXN timeout SW addr=00000700 req_cycles=%0d", n);

        // Flush during REQ: LHU 0x10, ack two cycles later, no response
        req_valid = 1'b1; opcode = OP_LHU; addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        check("fl_mem_en", mem_en, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_mem_en_held", mem_en, 1);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        check("fl_no_resp", resp_valid, 0);
        check("fl_req_ready", req_ready, 1);
        check("fl_mem_en_off", mem_en, 0);
        @(negedge clk);
        check("fl_still_no_resp", resp_valid, 0);
        $display("TXN flush-in-REQ LHU addr=00000010");

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1; opcode = OP_LW; addr = 32'h40; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("fi_req_ready", req_ready, 1);
        check("fi_idle", {mem_en, resp_valid}, 0);
        $display("TXN flush-in-IDLE LW addr=00000040");

        // Flush in RESP drops the response
        req_valid = 1'b1; opcode = OP_LW; addr = 32'h41;
        @(negedge clk);
        req_valid = 1'b0;
        check("fr_valid", resp_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fr_dropped", resp_valid, 0);
        check("fr_req_ready", req_ready, 1);
        $display("TXN flush-in-RESP LW addr=00000041");

        // Reset in the middle of a bus cycle
        req_valid = 1'b1; opcode = OP_LW; addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        check("rm_mem_en", mem_en, 1);
        #2 rst = 1'b1;
        #1;
        check("rm_mem_en_off", mem_en, 0);
        check("rm_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rm_no_resp", resp_valid, 0);
        $display("TXN reset-mid-access LW addr=00000080");

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            run_txn(ops[r], $urandom, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
